lsu_mem_master: RTL and testbench

Load/store initiator that drives the word-addressed, single-port data memory from the pipeline's memory stage. It accepts one byte-addressed load or store request at a time over a valid/ready handshake and issues the memory's memWrite/memRead/address/writeData controls. It performs read-modify-write for byte and halfword stores, and sign- or zero-extends loaded sub-words. It also returns a one-cycle response pulse with load data or a misalignment error.

---
 rtl/lsu_mem_master.sv | 220 ++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_master
//  Brief    : Load/store initiator for a word-addressed single-port data
//             memory. Takes one byte-addressed request at a time, does
//             read-modify-write for sub-word stores, extends sub-word loads
//             and returns a one-cycle response pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int MEM_AW = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    // request channel
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [MEM_AW+1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    // response channel
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    // memory port
    output logic [MEM_AW-1:0] mem_address_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;

    // latched request
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;

    // registered outputs
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [MEM_AW-1:0] mem_address_q, mem_address_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q, mem_read_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              req_err;
    logic [4:0]        lane_shamt;
    logic [31:0]       lane_mask;
    logic [31:0]       merged_word;
    logic [31:0]       shifted_rdata;
    logic [31:0]       extracted;

    // Ready is gated by rst_n so nothing is taken while reset is held.
    assign req_ready_o   = ready_q & rst_n;
    assign resp_valid_o  = resp_valid_q;
    assign resp_rdata_o  = resp_rdata_q;
    assign resp_err_o    = resp_err_q;
    assign mem_address_o = mem_address_q;
    assign mem_write_o   = mem_write_q;
    assign mem_read_o    = mem_read_q;
    assign mem_wdata_o   = mem_wdata_q;

    // Illegal size or misaligned half/word request, judged on live inputs.
    always_comb begin
        req_err = 1'b0;
        if (req_size_i == 2'b11) begin
            req_err = 1'b1;
        end else if (req_size_i == SZ_HALF && req_addr_i[0]) begin
            req_err = 1'b1;
        end else if (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00) begin
            req_err = 1'b1;
        end
    end

    // Lane position/mask, store merge and load extraction on latched request.
    always_comb begin
        lane_shamt = (size_q == SZ_BYTE) ? {off_q, 3'b000} : {off_q[1], 4'b0000};
        if (size_q == SZ_BYTE) begin
            lane_mask = 32'h0000_00FF << lane_shamt;
        end else begin
            lane_mask = 32'h0000_FFFF << lane_shamt;
        end
        merged_word   = (mem_rdata_i & ~lane_mask) | ((wdata_q << lane_shamt) & lane_mask);
        shifted_rdata = mem_rdata_i >> lane_shamt;
        case (size_q)
            SZ_BYTE: extracted = unsigned_q ? {24'h0, shifted_rdata[7:0]}
                                            : {{24{shifted_rdata[7]}}, shifted_rdata[7:0]};
            SZ_HALF: extracted = unsigned_q ? {16'h0, shifted_rdata[15:0]}
                                            : {{16{shifted_rdata[15]}}, shifted_rdata[15:0]};
            default: extracted = mem_rdata_i;
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        size_d        = size_q;
        unsigned_d    = unsigned_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = 32'h0;
        resp_err_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_write_d   = 1'b0;
        mem_read_d    = 1'b0;
        mem_wdata_d   = 32'h0;

        case (state_q)
            IDLE: begin
                mem_address_d = '0;
                if (req_valid_i && ready_q) begin
                    if (req_err) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        write_d       = req_write_i;
                        size_d        = req_size_i;
                        unsigned_d    = req_unsigned_i;
                        off_d         = req_addr_i[1:0];
                        wdata_d       = req_wdata_i;
                        mem_address_d = req_addr_i[MEM_AW+1:2];
                        if (req_write_i && req_size_i == SZ_WORD) begin
                            state_d     = WRITE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = req_wdata_i;
                        end else begin
                            state_d    = READ;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            READ: begin
                // memory registers the word on this edge
                state_d = WAIT;
            end
            WAIT: begin
                if (write_q) begin
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged_word;
                end else begin
                    state_d       = IDLE;
                    resp_valid_d  = 1'b1;
                    resp_rdata_d  = extracted;
                    mem_address_d = '0;
                end
            end
            WRITE: begin
                state_d       = IDLE;
                resp_valid_d  = 1'b1;
                mem_address_d = '0;
            end
            default: begin
                state_d       = IDLE;
                mem_address_d = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and output registers; reset aborts any operation silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            write_q       <= 1'b0;
            size_q        <= 2'b00;
            unsigned_q    <= 1'b0;
            off_q         <= 2'b00;
            wdata_q       <= 32'h0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'h0;
            resp_err_q    <= 1'b0;
            mem_address_q <= '0;
            mem_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_wdata_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            write_q       <= write_d;
            size_q        <= size_d;
            unsigned_q    <= unsigned_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_err_q    <= resp_err_d;
            mem_address_q <= mem_address_d;
            mem_write_q   <= mem_write_d;
            mem_read_q    <= mem_read_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_mem_master
//  Brief    : Self-checking bench for lsu_mem_master with a registered-read
//             word memory model, a vector table and corner-case sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

    localparam int MEM_AW = 7;

    logic              clk;
    logic              rst_n;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [1:0]        req_size_i;
    logic              req_unsigned_i;
    logic [MEM_AW+1:0] req_addr_i;
    logic [31:0]       req_wdata_i;
    logic              resp_valid_o;
    logic [31:0]       resp_rdata_o;
    logic              resp_err_o;
    logic [MEM_AW-1:0] mem_address_o;
    logic              mem_write_o;
    logic              mem_read_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    int tests = 0;
    int fails = 0;

    lsu_mem_master #(.MEM_AW(MEM_AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_address_o  (mem_address_o),
        .mem_write_o    (mem_write_o),
        .mem_read_o     (mem_read_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory with registered read data; no reset.
    logic [31:0] mem [0:(1<<MEM_AW)-1];
    always @(posedge clk) begin
        if (mem_write_o) mem[mem_address_o] <= mem_wdata_o;
        if (mem_read_o)  mem_rdata_i <= mem[mem_address_o];
    end

    // Read and write strobes must never overlap.
    always @(negedge clk) begin
        if (mem_read_o === 1'b1 && mem_write_o === 1'b1) begin
            fails++;
            $display("FAIL strobe_overlap: got rd=1 wr=1 expected at most one");
        end
    end

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          resp_cyc;
        int          rd_cyc;
        int          wr_cyc;
        logic [31:0] exp_mwdata;
    } vec_t;

    function automatic vec_t mk(logic wr, logic [1:0] sz, logic un, logic [8:0] a,
                                logic [31:0] wd, logic [31:0] er, logic ee,
                                int rc, int rdc, int wrc, logic [31:0] mw);
        vec_t v;
        v.wr = wr; v.sz = sz; v.un = un; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.resp_cyc = rc;
        v.rd_cyc = rdc; v.wr_cyc = wrc; v.exp_mwdata = mw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request and observe six cycles after acceptance.
    task automatic run_vec(input string tag, input vec_t v);
        int          n;
        int          resp_cyc, resp_cnt, rd_cyc, wr_cyc;
        logic [31:0] rdata, mwd;
        logic        err;
        logic [6:0]  rd_a, wr_a;
        resp_cyc = -1; resp_cnt = 0; rd_cyc = -1; wr_cyc = -1;
        rdata = '0; mwd = '0; err = 1'b0; rd_a = '0; wr_a = '0;
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_write_i    = v.wr;
        req_size_i     = v.sz;
        req_unsigned_i = v.un;
        req_addr_i     = v.addr;
        req_wdata_i    = v.wdata;
        n = 0;
        while (!req_ready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) begin
            chk({tag, " ready_timeout"}, 32'd0, 32'd1);
            req_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (resp_valid_o) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = c; rdata = resp_rdata_o; err = resp_err_o;
                end
            end
            if (mem_read_o && rd_cyc < 0) begin
                rd_cyc = c; rd_a = mem_address_o;
            end
            if (mem_write_o && wr_cyc < 0) begin
                wr_cyc = c; wr_a = mem_address_o; mwd = mem_wdata_o;
            end
        end
        chk({tag, " resp_cycle"}, resp_cyc, v.resp_cyc);
        chk({tag, " resp_count"}, resp_cnt, 1);
        chk({tag, " resp_rdata"}, rdata, v.exp_rdata);
        chk({tag, " resp_err"}, {31'h0, err}, {31'h0, v.exp_err});
        chk({tag, " read_cycle"}, rd_cyc, v.rd_cyc);
        chk({tag, " write_cycle"}, wr_cyc, v.wr_cyc);
        if (v.wr_cyc >= 0) begin
            chk({tag, " mem_wdata"}, mwd, v.exp_mwdata);
            chk({tag, " wr_addr"}, {25'h0, wr_a}, {25'h0, v.addr[8:2]});
        end
        if (v.rd_cyc >= 0) begin
            chk({tag, " rd_addr"}, {25'h0, rd_a}, {25'h0, v.addr[8:2]});
        end
    endtask

    vec_t vecs [22];

    initial begin
        logic saw_wr, saw_resp;
        // wr sz un addr wdata exp_rdata err resp rd wr mwdata
        vecs[0]  = mk(1, 2'b10, 0, 9'h010, 32'hDEADBEEF, 32'h0,        0, 1, -1,  0, 32'hDEADBEEF);
        vecs[1]  = mk(0, 2'b10, 0, 9'h010, 32'h0,        32'hDEADBEEF, 0, 2,  0, -1, 32'h0);
        vecs[2]  = mk(1, 2'b10, 0, 9'h010, 32'h11223344, 32'h0,        0, 1, -1,  0, 32'h11223344);
        vecs[3]  = mk(1, 2'b00, 0, 9'h012, 32'h000000AA, 32'h0,        0, 3,  0,  2, 32'h11AA3344);
        vecs[4]  = mk(0, 2'b00, 0, 9'h012, 32'h0,        32'hFFFFFFAA, 0, 2,  0, -1, 32'h0);
        vecs[5]  = mk(0, 2'b00, 1, 9'h012, 32'h0,        32'h000000AA, 0, 2,  0, -1, 32'h0);
        vecs[6]  = mk(0, 2'b00, 0, 9'h013, 32'h0,        32'h00000011, 0, 2,  0, -1, 32'h0);
        vecs[7]  = mk(0, 2'b01, 1, 9'h010, 32'h0,        32'h00003344, 0, 2,  0, -1, 32'h0);
        vecs[8]  = mk(0, 2'b10, 0, 9'h010, 32'h0,        32'h11AA3344, 0, 2,  0, -1, 32'h0);
        vecs[9]  = mk(1, 2'b10, 0, 9'h014, 32'h00000000, 32'h0,        0, 1, -1,  0, 32'h00000000);
        vecs[10] = mk(1, 2'b01, 0, 9'h016, 32'h00008001, 32'h0,        0, 3,  0,  2, 32'h80010000);
        vecs[11] = mk(0, 2'b01, 0, 9'h016, 32'h0,        32'hFFFF8001, 0, 2,  0, -1, 32'h0);
        vecs[12] = mk(0, 2'b01, 1, 9'h016, 32'h0,        32'h00008001, 0, 2,  0, -1, 32'h0);
        vecs[13] = mk(1, 2'b00, 0, 9'h017, 32'h0000007F, 32'h0,        0, 3,  0,  2, 32'h7F010000);
        vecs[14] = mk(0, 2'b10, 0, 9'h014, 32'h0,        32'h7F010000, 0, 2,  0, -1, 32'h0);
        vecs[15] = mk(0, 2'b10, 0, 9'h013, 32'h0,        32'h0,        1, 0, -1, -1, 32'h0);
        vecs[16] = mk(1, 2'b01, 0, 9'h011, 32'h00001234, 32'h0,        1, 0, -1, -1, 32'h0);
        vecs[17] = mk(0, 2'b11, 0, 9'h010, 32'h0,        32'h0,        1, 0, -1, -1, 32'h0);
        vecs[18] = mk(1, 2'b00, 0, 9'h010, 32'hFFFFFF5A, 32'h0,        0, 3,  0,  2, 32'h11AA335A);
        vecs[19] = mk(0, 2'b00, 0, 9'h010, 32'h0,        32'h0000005A, 0, 2,  0, -1, 32'h0);
        vecs[20] = mk(0, 2'b01, 0, 9'h012, 32'h0,        32'h000011AA, 0, 2,  0, -1, 32'h0);
        vecs[21] = mk(0, 2'b00, 0, 9'h011, 32'h0,        32'h00000033, 0, 2,  0, -1, 32'h0);

        // Reset held two edges with a request present.
        rst_n = 1'b0;
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b10;
        req_unsigned_i = 1'b0; req_addr_i = 9'h010; req_wdata_i = 32'h12345678;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst req_ready", {31'h0, req_ready_o}, 32'h0);
            chk("rst mem_strobes", {30'h0, mem_read_o, mem_write_o}, 32'h0);
            chk("rst resp", {31'h0, resp_valid_o}, 32'h0);
            chk("rst outputs", resp_rdata_o | mem_wdata_o | {25'h0, mem_address_o} | {31'h0, resp_err_o}, 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst ready", {31'h0, req_ready_o}, 32'h1);
        chk("post_rst no_write", {31'h0, mem_write_o}, 32'h0);
        req_valid_i = 1'b0;

        for (int i = 0; i < 22; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Back-to-back word stores: second taken in the first one's response cycle.
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b10;
        req_unsigned_i = 1'b0; req_addr_i = 9'h020; req_wdata_i = 32'hA5A5A5A5;
        chk("b2b ready0", {31'h0, req_ready_o}, 32'h1);
        @(posedge clk);
        #1 req_addr_i = 9'h024; req_wdata_i = 32'h5A5A5A5A;
        @(negedge clk);
        chk("b2b first_write", {31'h0, mem_write_o}, 32'h1);
        @(negedge clk);
        chk("b2b resp_and_ready", {30'h0, resp_valid_o, req_ready_o}, 32'h3);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("b2b second_write", {mem_write_o, 24'h0, mem_address_o}, {1'b1, 24'h0, 7'd9});
        chk("b2b second_wdata", mem_wdata_o, 32'h5A5A5A5A);
        @(negedge clk);
        chk("b2b second_resp", {31'h0, resp_valid_o}, 32'h1);
        chk("b2b mem8", mem[8], 32'hA5A5A5A5);

        // Reset during WAIT of a sub-word store aborts the write.
        run_vec("pre_abort", mk(1, 2'b10, 0, 9'h018, 32'hCAFEF00D, 32'h0, 0, 1, -1, 0, 32'hCAFEF00D));
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = 9'h018; req_wdata_i = 32'h00000055;
        chk("abort ready", {31'h0, req_ready_o}, 32'h1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("abort read_strobe", {31'h0, mem_read_o}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        saw_wr = 1'b0; saw_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_write_o) saw_wr = 1'b1;
            if (resp_valid_o) saw_resp = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_write_o) saw_wr = 1'b1;
            if (resp_valid_o) saw_resp = 1'b1;
        end
        chk("abort no_write", {31'h0, saw_wr}, 32'h0);
        chk("abort no_resp", {31'h0, saw_resp}, 32'h0);
        chk("abort mem6", mem[6], 32'hCAFEF00D);
        run_vec("after_abort", mk(0, 2'b10, 0, 9'h018, 32'h0, 32'hCAFEF00D, 0, 2, 0, -1, 32'h0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
